mux_arb_n: RTL and testbench
============================

Name: mux_arb_n

Overview:
Parametrised successor to the team's 4-to-1 select mux. It takes CHANNELS input channels of WIDTH bits, each with a valid/ready handshake, and forwards one of them to a single registered output. Selection is either fixed (external select S) or round-robin arbitration. It sits between multiple datapath sources (register file read ports, ALU, memory return) and a shared bus or writeback stage in the DE0 processor.

Parameters:
WIDTH, 8, data width per channel in bits
CHANNELS, 4, number of input channels, from 2 to 16
SEL_W, 2, select and index width; must satisfy 2^SEL_W >= CHANNELS

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  asynchronous active-low reset
MODE  input  1  0 = fixed select via S; 1 = round-robin
S  input  SEL_W  channel index used when MODE=0
IN_VALID  input  CHANNELS  per-channel valid; bit k belongs to channel k
IN_DATA  input  CHANNELS*WIDTH  packed data; channel k occupies bits [k*WIDTH +: WIDTH]
IN_READY  output  CHANNELS  per-channel ready (combinational)
OUT_VALID  output  1  output register holds valid data
OUT_DATA  output  WIDTH  registered output data
OUT_SEL  output  SEL_W  index of the channel that produced OUT_DATA
OUT_READY  input  1  downstream accepts OUT_DATA

Behaviour:
- Clock and reset: one clock, CLK. Reset RST_N is asynchronous and active-low.
- Reset values: OUT_VALID=0, OUT_DATA=0, OUT_SEL=0, internal round-robin pointer PTR=0. IN_READY is forced to all zeros while RST_N=0.
- Load enable: load = ~OUT_VALID | OUT_READY. When the output register is empty or being drained this cycle, it can capture a new word.
- Grant logic (combinational, one-hot or zero):
  - MODE=0: grant channel S when S<CHANNELS and IN_VALID[S]=1. If S>=CHANNELS, there is no grant.
  - MODE=1: grant the first channel with IN_VALID=1, searching PTR, PTR+1, … and wrapping modulo CHANNELS.
- Handshake outputs: IN_READY[k] = load & grant[k]. At most one bit of IN_READY is high in any cycle.
- Input transfer: occurs when IN_VALID[k] & IN_READY[k] at a rising CLK edge. On that edge:
  - OUT_DATA <= channel k data
  - OUT_SEL <= k
  - OUT_VALID <= 1
- Output transfer: occurs when OUT_VALID & OUT_READY. If there is no simultaneous input transfer, OUT_VALID <= 0 and OUT_DATA/OUT_SEL hold their last values.
- Simultaneous drain and load: the old word leaves and the new word is captured on the same edge. Sustained throughput is 1 word per cycle.
- Latency: 1 cycle from input accept to OUT_VALID.
- Stall: while OUT_VALID=1 and OUT_READY=0, OUT_DATA and OUT_SEL are held stable and IN_READY is all zeros.
- PTR update:
  - MODE=1: on each input transfer from channel g, PTR <= (g+1) mod CHANNELS. g=CHANNELS-1 wraps PTR to 0.
  - MODE=0: PTR is unchanged.
  - PTR never takes a value >= CHANNELS.
- MODE or S changes take effect in the same cycle's grant computation. They never alter a word already held in the output register.
- Input-side rule: a source must hold IN_DATA stable while IN_VALID=1 and IN_READY=0. The block does not latch unaccepted inputs.
- Reset mid-transfer: an asserted RST_N=0 immediately clears OUT_VALID, regardless of any pending handshake. The held word is discarded.
- No valid inputs: no grant, and OUT_VALID falls after draining.

Test Plan:
- Reset then idle: RST_N low with all IN_VALID=1 -> IN_READY=0000, OUT_VALID=0, OUT_DATA=0. After release with OUT_READY=1 and MODE=0, S=2, IN_DATA ch2=0xA5 -> OUT_VALID=1, OUT_DATA=0xA5, OUT_SEL=2 one cycle later.
- Fixed-mode stall: MODE=0, S=1, ch1 valid with 0x3C, OUT_READY=0 for 3 cycles -> OUT_DATA stays 0x3C, IN_READY=0000 during the stall. When OUT_READY rises, next word 0x3D is accepted with no gap cycle.
- Round-robin fairness: MODE=1, all 4 channels valid continuously, OUT_READY=1 -> OUT_SEL sequence 0,1,2,3,0,1 on consecutive cycles. PTR wraps from 3 to 0.
- Round-robin skip: MODE=1, PTR=1, only ch0 and ch3 valid -> grant order 3, then 0, then 3.
- Out-of-range select: CHANNELS=3, MODE=0, S=3, all valid -> IN_READY=000, OUT_VALID stays 0.
- Async reset mid-stream: MODE=1 streaming with OUT_VALID=1, pulse RST_N low between clock edges -> OUT_VALID drops immediately. After release, the first grant goes to ch0 (PTR=0).

Source files
------------

// File: rtl/mux_arb_n.sv
// N-channel valid/ready mux with a single registered output stage.
// The source is chosen either by the external index S or by a round-robin pointer.
module mux_arb_n #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = 2
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         MODE,
  input  logic [SEL_W-1:0]             S,
  input  logic [CHANNELS-1:0]          IN_VALID,
  input  logic [CHANNELS*WIDTH-1:0]    IN_DATA,
  output logic [CHANNELS-1:0]          IN_READY,
  output logic                         OUT_VALID,
  output logic [WIDTH-1:0]             OUT_DATA,
  output logic [SEL_W-1:0]             OUT_SEL,
  input  logic                         OUT_READY
);

  typedef enum logic {
    SEL_FIXED = 1'b0,
    SEL_RR    = 1'b1
  } sel_mode_e;

  sel_mode_e        sel_mode;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] ptr_next;

  logic             fix_hit;
  logic             rr_lo_hit;
  logic             rr_hi_hit;
  logic [SEL_W-1:0] rr_lo_idx;
  logic [SEL_W-1:0] rr_hi_idx;

  logic             gnt_valid;
  logic [SEL_W-1:0] gnt_idx;
  logic             load;
  logic             take;
  logic [WIDTH-1:0] gnt_data;

  assign sel_mode = sel_mode_e'(MODE);
  assign load     = ~OUT_VALID | OUT_READY;

  // Wrapped search from ptr: prefer the lowest valid index at or above ptr,
  // otherwise fall back to the lowest valid index overall.
  always_comb begin
    fix_hit   = 1'b0;
    rr_lo_hit = 1'b0;
    rr_hi_hit = 1'b0;
    rr_lo_idx = '0;
    rr_hi_idx = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (IN_VALID[k]) begin
        if (S == SEL_W'(k)) begin
          fix_hit = 1'b1;
        end
        if (!rr_lo_hit) begin
          rr_lo_hit = 1'b1;
          rr_lo_idx = SEL_W'(k);
        end
        if (!rr_hi_hit && (SEL_W'(k) >= ptr)) begin
          rr_hi_hit = 1'b1;
          rr_hi_idx = SEL_W'(k);
        end
      end
    end
  end

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    unique case (sel_mode)
      SEL_FIXED: begin
        gnt_valid = fix_hit;
        gnt_idx   = S;
      end
      SEL_RR: begin
        gnt_valid = rr_lo_hit;
        gnt_idx   = rr_hi_hit ? rr_hi_idx : rr_lo_idx;
      end
      default: begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
      end
    endcase
  end

  assign take = gnt_valid & load & RST_N;

  always_comb begin
    IN_READY = '0;
    gnt_data = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (gnt_idx == SEL_W'(k)) begin
        IN_READY[k] = take;
        gnt_data    = IN_DATA[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    if (32'(gnt_idx) == CHANNELS - 1) begin
      ptr_next = '0;
    end else begin
      ptr_next = gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OUT_VALID <= 1'b0;
      OUT_DATA  <= '0;
      OUT_SEL   <= '0;
      ptr       <= '0;
    end else begin
      if (take) begin
        OUT_VALID <= 1'b1;
        OUT_DATA  <= gnt_data;
        OUT_SEL   <= gnt_idx;
        if (sel_mode == SEL_RR) begin
          ptr <= ptr_next;
        end
      end else if (OUT_READY) begin
        OUT_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_arb_n.sv
// Scoreboard bench for mux_arb_n: a 4-channel instance for the main checks
// and a 3-channel instance for the out-of-range select case.
module tb_mux_arb_n;

  logic        CLK;
  logic        RST_N;
  logic        MODE;
  logic [1:0]  S;
  logic [3:0]  IN_VALID;
  logic [31:0] IN_DATA;
  logic [3:0]  IN_READY;
  logic        OUT_VALID;
  logic [7:0]  OUT_DATA;
  logic [1:0]  OUT_SEL;
  logic        OUT_READY;

  logic [1:0]  s3;
  logic [2:0]  in_valid3;
  logic [23:0] in_data3;
  logic [2:0]  in_ready3;
  logic        out_valid3;
  logic [7:0]  out_data3;
  logic [1:0]  out_sel3;
  logic        out_ready3;

  int n_checks = 0;
  int n_bad    = 0;

  logic       m_ov;
  int         m_ptr;
  logic [7:0] m_data;
  logic [1:0] m_sel;
  logic [9:0] sb_q[$];

  mux_arb_n #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .MODE(MODE), .S(S),
    .IN_VALID(IN_VALID), .IN_DATA(IN_DATA), .IN_READY(IN_READY),
    .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA), .OUT_SEL(OUT_SEL),
    .OUT_READY(OUT_READY)
  );

  mux_arb_n #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) dut3 (
    .CLK(CLK), .RST_N(RST_N), .MODE(MODE), .S(s3),
    .IN_VALID(in_valid3), .IN_DATA(in_data3), .IN_READY(in_ready3),
    .OUT_VALID(out_valid3), .OUT_DATA(out_data3), .OUT_SEL(out_sel3),
    .OUT_READY(out_ready3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_grant(input logic mode, input logic [1:0] s,
                                   input logic [3:0] v, input int ptr);
    if (!mode) begin
      return v[s] ? int'(s) : -1;
    end
    for (int off = 0; off < 4; off++) begin
      int c;
      c = (ptr + off) % 4;
      if (((v >> c) & 4'b0001) != 4'b0000) return c;
    end
    return -1;
  endfunction

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input logic mode, input logic [1:0] s, input logic [3:0] v,
                      input logic [31:0] d, input logic ordy);
    int         g;
    logic       xfer;
    logic [3:0] exp_rdy;
    logic [9:0] ent;
    MODE = mode; S = s; IN_VALID = v; IN_DATA = d; OUT_READY = ordy;
    #1;
    g       = exp_grant(mode, s, v, m_ptr);
    xfer    = (g >= 0) && (!m_ov || ordy);
    exp_rdy = xfer ? 4'(1 << g) : 4'b0000;
    check_val("in_ready", 32'(IN_READY), 32'(exp_rdy));
    if (xfer) begin
      sb_q.push_back({2'(g), 8'(d >> (8 * g))});
      m_ov = 1'b1;
      if (mode) m_ptr = (g + 1) % 4;
    end else if (ordy) begin
      m_ov = 1'b0;
    end
    @(posedge CLK);
    #1;
    check_val("out_valid", 32'(OUT_VALID), 32'(m_ov));
    if (xfer) begin
      ent    = sb_q.pop_front();
      m_data = ent[7:0];
      m_sel  = ent[9:8];
    end
    if (m_ov) begin
      check_val("out_data", 32'(OUT_DATA), 32'(m_data));
      check_val("out_sel", 32'(OUT_SEL), 32'(m_sel));
    end
    @(negedge CLK);
  endtask

  int exp_rr[6]   = '{0, 1, 2, 3, 0, 1};
  int exp_skip[3] = '{3, 0, 3};

  initial begin
    RST_N = 1'b0; MODE = 1'b0; S = 2'd2; IN_VALID = 4'hF; IN_DATA = '0; OUT_READY = 1'b1;
    s3 = 2'd0; in_valid3 = 3'b111; in_data3 = '0; out_ready3 = 1'b1;
    m_ov = 1'b0; m_ptr = 0; m_data = '0; m_sel = '0;

    @(negedge CLK);
    @(negedge CLK);
    check_val("rst_in_ready", 32'(IN_READY), 32'h0);
    check_val("rst_in_ready3", 32'(in_ready3), 32'h0);
    check_val("rst_out_valid", 32'(OUT_VALID), 32'h0);
    check_val("rst_out_data", 32'(OUT_DATA), 32'h0);
    check_val("rst_out_sel", 32'(OUT_SEL), 32'h0);
    RST_N = 1'b1;
    in_valid3 = 3'b000;
    IN_VALID = 4'h0;
    @(negedge CLK);

    // First word after reset, fixed select of channel 2
    step(1'b0, 2'd2, 4'b0100, 32'h00A5_0000, 1'b1);
    check_val("first_data", 32'(OUT_DATA), 32'hA5);
    check_val("first_sel", 32'(OUT_SEL), 32'd2);
    step(1'b0, 2'd2, 4'b0000, 32'h0, 1'b1);

    // Fixed-mode stall then back-to-back accept
    step(1'b0, 2'd1, 4'b0010, 32'h0000_3C00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'd1, 4'b0010, 32'h0000_3D00, 1'b0);
      check_val("stall_data", 32'(OUT_DATA), 32'h3C);
    end
    step(1'b0, 2'd1, 4'b0010, 32'h0000_3D00, 1'b1);
    check_val("nogap_data", 32'(OUT_DATA), 32'h3D);
    step(1'b0, 2'd1, 4'b0000, 32'h0, 1'b1);

    // Round-robin fairness, all channels requesting
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 2'd0, 4'hF, 32'h4433_2211, 1'b1);
      check_val("rr_seq", 32'(OUT_SEL), 32'(exp_rr[i]));
    end

    // Park the pointer at 1, then only ch0 and ch3 request
    step(1'b1, 2'd0, 4'b0001, 32'h0000_0077, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'd0, 4'b1001, 32'hC300_00C0, 1'b1);
      check_val("rr_skip", 32'(OUT_SEL), 32'(exp_skip[i]));
    end

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
           $urandom, ($urandom_range(0, 3) != 0));
    end

    // Async reset in the middle of a round-robin stream
    step(1'b1, 2'd0, 4'hF, 32'h4433_2211, 1'b1);
    step(1'b1, 2'd0, 4'hF, 32'h4433_2211, 1'b1);
    #2;
    RST_N = 1'b0;
    #1;
    check_val("arst_out_valid", 32'(OUT_VALID), 32'h0);
    check_val("arst_in_ready", 32'(IN_READY), 32'h0);
    check_val("arst_out_data", 32'(OUT_DATA), 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    m_ov = 1'b0; m_ptr = 0; sb_q.delete();
    step(1'b1, 2'd0, 4'hF, 32'h4433_2211, 1'b1);
    check_val("arst_first_sel", 32'(OUT_SEL), 32'h0);
    step(1'b1, 2'd0, 4'h0, 32'h0, 1'b1);
    IN_VALID = 4'h0;

    // Three-channel instance: S=3 is out of range
    MODE = 1'b0; s3 = 2'd3; in_valid3 = 3'b111; in_data3 = 24'h12_3456;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val("oor_in_ready", 32'(in_ready3), 32'h0);
      @(posedge CLK);
      #1;
      check_val("oor_out_valid", 32'(out_valid3), 32'h0);
      @(negedge CLK);
    end
    s3 = 2'd2;
    #1;
    check_val("ch3_in_ready", 32'(in_ready3), 32'h4);
    @(posedge CLK);
    #1;
    check_val("ch3_out_valid", 32'(out_valid3), 32'h1);
    check_val("ch3_out_data", 32'(out_data3), 32'h12);
    check_val("ch3_out_sel", 32'(out_sel3), 32'h2);
    @(negedge CLK);
    in_valid3 = 3'b000;

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
